not_not_round_judge: RTL and testbench
======================================

Name: not_not_round_judge

Overview:
- Downstream consumer of the prompt generator: takes the 4-bit expected-answer mask (which colour switches count as correct) and judges the player's answer.
- Runs the round loop: requests a new prompt, latches the mask, runs a per-round timeout, judges the answer or the timeout, and keeps score and lives.
- Its next_round pulse is the enable for the prompt LFSRs.
- Its outputs feed the HEX/LED display logic.

Parameters:
- ROUND_CYCLES, 100000000, clock cycles allowed per round (2 s at 50 MHz); must be >= 2
- LIVES, 3, lives at game start; must be 1..7
- SCORE_W, 8, score width

Ports:
- clock  in  1  system clock (CLOCK_50)
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; starts or restarts a game from IDLE or OVER
- expected  in  4  expected-answer mask from the prompt stage; bit i = colour i is acceptable
- answer_valid  in  1  one-cycle pulse, player committed an answer
- answer  in  4  player switch vector; valid only with answer_valid
- next_round  out  1  one-cycle pulse; advances the prompt LFSRs
- round_active  out  1  high while in WAIT
- result_valid  out  1  one-cycle pulse when a round is judged
- correct  out  1  verdict of the last judged round; holds until the next judgement
- score  out  SCORE_W  rounds won this game; saturates at all-ones
- lives  out  3  remaining lives
- game_over  out  1  high in OVER

Behaviour:
- Reset (async, any state, including mid-round):
  - state=IDLE.
  - All outputs 0: score=0, lives=0, correct=0, no pulses.
  - Timer and latched mask cleared.
- States: IDLE, REQ, SETTLE, LATCH, WAIT, JUDGE, OVER.
- IDLE:
  - start -> score=0, lives=LIVES, correct=0; go REQ.
  - answer_valid ignored.
- REQ: next_round=1 for exactly this cycle; go SETTLE.
- SETTLE: one cycle for the LFSR outputs and combinational mask to settle; go LATCH.
- LATCH:
  - exp_q<=expected, timer<=ROUND_CYCLES-1; go WAIT.
  - The mask is sampled exactly 2 cycles after the next_round cycle.
- WAIT (round_active=1):
  - answer_valid=1 -> hit = (answer is exactly one-hot) AND (answer & exp_q) != 0; go JUDGE.
  - No answer and timer==0 -> hit = (exp_q==4'b0000), so "press nothing" is correct only for an empty mask; go JUDGE.
  - Otherwise timer decrements by 1.
  - answer_valid in the same cycle as timer==0: the answer wins.
  - answer=0 or multiple bits set -> hit=0.
- JUDGE (result_valid=1 this cycle; correct<=hit):
  - hit -> score+1, saturating at 2^SCORE_W-1; go REQ.
  - miss -> lives-1; if the new lives==0 go OVER, else go REQ.
  - Score and lives update on the clock edge that leaves JUDGE; they are visible the cycle after the result_valid pulse.
- OVER (game_over=1):
  - Score, lives=0 and correct hold.
  - start -> same as from IDLE.
  - answer_valid ignored.
- start outside IDLE/OVER is ignored.
- answer_valid outside WAIT is ignored and is not queued.
- expected changes outside LATCH have no effect on the current round.
- Round length:
  - Timeout: ROUND_CYCLES WAIT cycles, then one JUDGE cycle.
  - Minimum round-to-round period: REQ+SETTLE+LATCH+1 WAIT+JUDGE = 5 cycles.
- No combinational path from inputs to outputs; all outputs are registered or decoded from the state register.

Test Plan (ROUND_CYCLES=8, LIVES=3, SCORE_W=8):
1. Reset asserted mid-WAIT with score=2 -> same cycle: score=0, lives=0, round_active=0. After release, start -> next_round pulses 1 cycle later, lives=3.
2. expected=4'b0110 at LATCH; answer_valid with answer=4'b0100 on the 3rd WAIT cycle -> result_valid, correct=1, score 0->1; next_round pulses the cycle after JUDGE.
3. expected=4'b0110; answer=4'b0110 (two bits), then a later round with answer=4'b0001 -> both correct=0, lives 3->2->1, score unchanged.
4. expected=4'b0000, no answer -> result_valid exactly 8 cycles after entering WAIT, correct=1. Same with expected=4'b1000 -> correct=0, lives decrements.
5. answer_valid coincident with timer==0 and a matching answer -> correct=1 (answer wins, not a timeout). answer_valid during SETTLE -> ignored, round proceeds to timeout.
6. Three consecutive misses -> game_over=1 the cycle after the 3rd JUDGE, lives=0, no next_round. Score saturation: preload via 255 wins, one more win -> score stays 255. start in OVER -> score=0, lives=3, new round.

Source files
------------

// File: rtl/not_not_round_judge.sv
`default_nettype none
// ============================================================================
// Module   : not_not_round_judge
// Purpose  : Round sequencer and answer judge; keeps score and lives.
// Revision : 1.0 - initial release
// ============================================================================
module not_not_round_judge #(
  parameter int ROUND_CYCLES = 100000000,
  parameter int LIVES        = 3,
  parameter int SCORE_W      = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         expected,
  input  logic               answer_valid,
  input  logic [3:0]         answer,
  output logic               next_round,
  output logic               round_active,
  output logic               result_valid,
  output logic               correct,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic               game_over
);

  localparam int TIMER_W = $clog2(ROUND_CYCLES);
  localparam logic [TIMER_W-1:0] C_TIMER_LOAD = TIMER_W'(ROUND_CYCLES - 1);
  localparam logic [2:0] C_LIVES = 3'(LIVES);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_LATCH  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_JUDGE  = 3'd5;
  localparam logic [2:0] S_OVER   = 3'd6;

  logic [2:0]         r_state;
  logic [TIMER_W-1:0] r_timer;
  logic [3:0]         r_exp;
  logic               r_hit;
  logic               r_correct;
  logic [SCORE_W-1:0] r_score;
  logic [2:0]         r_lives;

  logic w_onehot;
  logic w_hit_answer;
  logic w_hit_timeout;

  // A valid answer is exactly one switch, and that switch must be in the mask
  assign w_onehot      = (answer != 4'd0) && ((answer & (answer - 4'd1)) == 4'd0);
  assign w_hit_answer  = w_onehot && ((answer & r_exp) != 4'd0);
  assign w_hit_timeout = (r_exp == 4'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_exp     <= 4'd0;
      r_hit     <= 1'b0;
      r_correct <= 1'b0;
      r_score   <= '0;
      r_lives   <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE, S_OVER: begin
          if (start) begin
            r_score   <= '0;
            r_lives   <= C_LIVES;
            r_correct <= 1'b0;
            r_state   <= S_REQ;
          end
        end
        S_REQ:    r_state <= S_SETTLE;
        S_SETTLE: r_state <= S_LATCH;
        S_LATCH: begin
          r_exp   <= expected;
          r_timer <= C_TIMER_LOAD;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // An answer arriving on the last timer cycle takes priority over timeout
          if (answer_valid) begin
            r_hit   <= w_hit_answer;
            r_state <= S_JUDGE;
          end else if (r_timer == '0) begin
            r_hit   <= w_hit_timeout;
            r_state <= S_JUDGE;
          end else begin
            r_timer <= r_timer - TIMER_W'(1);
          end
        end
        S_JUDGE: begin
          r_correct <= r_hit;
          if (r_hit) begin
            if (r_score != '1) r_score <= r_score + SCORE_W'(1);
            r_state <= S_REQ;
          end else begin
            r_lives <= r_lives - 3'd1;
            r_state <= (r_lives == 3'd1) ? S_OVER : S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign next_round   = (r_state == S_REQ);
  assign round_active = (r_state == S_WAIT);
  assign result_valid = (r_state == S_JUDGE);
  assign game_over    = (r_state == S_OVER);
  assign correct      = r_correct;
  assign score        = r_score;
  assign lives        = r_lives;

endmodule
`default_nettype wire

// File: tb/tb_not_not_round_judge.sv
`default_nettype none
// ============================================================================
// Module   : tb_not_not_round_judge
// Purpose  : Self-checking bench for the round judge against a rule-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_not_not_round_judge;

  localparam int RC = 8;
  localparam int LV = 3;
  localparam int SW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    expected = 4'd0;
  logic          answer_valid = 1'b0;
  logic [3:0]    answer = 4'd0;
  logic          next_round, round_active, result_valid, correct, game_over;
  logic [SW-1:0] score;
  logic [2:0]    lives;

  not_not_round_judge #(.ROUND_CYCLES(RC), .LIVES(LV), .SCORE_W(SW)) dut (
    .clock(clock), .reset(reset), .start(start), .expected(expected),
    .answer_valid(answer_valid), .answer(answer), .next_round(next_round),
    .round_active(round_active), .result_valid(result_valid), .correct(correct),
    .score(score), .lives(lives), .game_over(game_over)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;
  int m_score = 0;
  int m_lives = 0;
  int m_correct = 0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Rule: a single pressed switch that belongs to the mask wins; silence wins only on an empty mask
  function automatic int model_hit(input logic [3:0] e, input logic [3:0] a, input bit answered);
    int ones;
    if (!answered) return (e == 4'd0) ? 1 : 0;
    ones = 0;
    for (int i = 0; i < 4; i++) ones += int'(a[i]);
    return (ones == 1 && (a & e) != 4'd0) ? 1 : 0;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".score"},     32'(score),     32'(m_score));
    chk({tag, ".lives"},     32'(lives),     32'(m_lives));
    chk({tag, ".correct"},   32'(correct),   32'(m_correct));
    chk({tag, ".game_over"}, 32'(game_over), (m_lives == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    m_score = 0; m_lives = LV; m_correct = 0;
    check_state("start");
  endtask

  // Entered while the DUT shows the REQ cycle; leaves at the cycle after JUDGE
  task automatic play_round(input logic [3:0] e, input int ans_cycle, input logic [3:0] a,
                            input bit settle_poke);
    int lat;
    bit got;
    bit answered;
    int hit;
    chk("req.next_round", 32'(next_round), 32'd1);
    expected = 4'($urandom);
    step();
    if (settle_poke) begin
      answer_valid = 1'b1;
      answer = (e != 4'd0) ? e : 4'b0001;
    end
    expected = 4'($urandom);
    step();
    answer_valid = 1'b0;
    expected = e;
    step();
    expected = 4'($urandom);
    chk("wait.round_active", 32'(round_active), 32'd1);
    got = 1'b0;
    lat = 0;
    for (int w = 0; w < RC + 2 && !got; w++) begin
      if (w == ans_cycle) begin
        answer_valid = 1'b1; answer = a;
      end else begin
        answer_valid = 1'b0; answer = 4'($urandom);
      end
      step();
      lat++;
      if (result_valid === 1'b1) got = 1'b1;
    end
    answer_valid = 1'b0;
    chk("judge.seen", 32'(got), 32'd1);
    if (!got) return;
    answered = (ans_cycle >= 0 && ans_cycle < RC);
    chk("judge.latency", 32'(lat), answered ? 32'(ans_cycle + 1) : 32'(RC));
    hit = model_hit(e, a, answered);
    m_correct = hit;
    if (hit != 0) m_score = (m_score == (1 << SW) - 1) ? m_score : m_score + 1;
    else m_lives = m_lives - 1;
    step();
    check_state("after_judge");
    chk("after_judge.next_round", 32'(next_round), (m_lives != 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    step();
    step();
    chk("reset.score", 32'(score), 32'd0);
    chk("reset.lives", 32'(lives), 32'd0);
    chk("reset.pulses", {29'd0, next_round, result_valid, round_active}, 32'd0);
    chk("reset.flags", {30'd0, correct, game_over}, 32'd0);
    reset = 1'b0;
    answer_valid = 1'b1; answer = 4'b0001;
    step();
    answer_valid = 1'b0;
    chk("idle.ignore_answer", {30'd0, next_round, round_active}, 32'd0);

    // Two wins, then reset asynchronously in the middle of a WAIT
    do_start();
    play_round(4'b0110, 0, 4'b0100, 1'b0);
    play_round(4'b0011, 1, 4'b0001, 1'b0);
    chk("pre_reset.score", 32'(score), 32'd2);
    step(); step(); step();
    chk("pre_reset.round_active", 32'(round_active), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset.score", 32'(score), 32'd0);
    chk("async_reset.lives", 32'(lives), 32'd0);
    chk("async_reset.round_active", 32'(round_active), 32'd0);
    step();
    reset = 1'b0;
    step();
    do_start();

    // Directed rounds: one-hot hit, multi-bit miss, wrong-colour miss, empty mask timeout, timeout miss
    play_round(4'b0110, 2, 4'b0100, 1'b0);
    play_round(4'b0110, 2, 4'b0110, 1'b0);
    play_round(4'b0110, 1, 4'b0001, 1'b0);
    play_round(4'b0000, -1, 4'b0000, 1'b0);
    play_round(4'b1000, -1, 4'b0000, 1'b0);
    chk("over.game_over", 32'(game_over), 32'd1);

    // Answer on the timer==0 cycle wins; an answer during SETTLE is dropped
    do_start();
    play_round(4'b0010, RC - 1, 4'b0010, 1'b0);
    play_round(4'b0100, -1, 4'b0000, 1'b1);

    // Randomized rounds
    for (int r = 0; r < 40; r++) begin
      logic [3:0] e;
      logic [3:0] a;
      int ac;
      if (m_lives == 0) do_start();
      e  = 4'($urandom);
      ac = int'($urandom_range(0, RC)) - 1;
      a  = ($urandom_range(0, 1) == 1) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
      play_round(e, ac, a, 1'($urandom_range(0, 1)));
    end

    // Saturate the score, then lose all lives
    if (m_lives == 0) do_start();
    for (int r = 0; r < 256; r++) play_round(4'b0110, 0, 4'b0010, 1'b0);
    chk("saturate.score", 32'(score), 32'd255);
    while (m_lives > 0) play_round(4'b1000, -1, 4'b0000, 1'b0);
    answer_valid = 1'b1; answer = 4'b1000;
    step();
    answer_valid = 1'b0;
    step();
    chk("over.no_next_round", 32'(next_round), 32'd0);
    check_state("over.hold");
    do_start();
    play_round(4'b0001, 3, 4'b0001, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
